// File: rtl/hardwired_control_unit.sv
// Multi-cycle hardwired controller for the ALU-system datapath.
// Ports: Clock/Reset, IROut + Z/C/N/O flags in; RF/ARF/IR/DR/ALU/Mem/Mux controls, T, Halted, Illegal out.
`timescale 1ns/1ps
module hardwired_control_unit #(
    parameter logic [4:0] ALU_ADD = 5'b10100,
    parameter logic [5:0] OP_NOP  = 6'h00,
    parameter logic [5:0] OP_INC  = 6'h01,
    parameter logic [5:0] OP_LDI  = 6'h02,
    parameter logic [5:0] OP_ADD  = 6'h03,
    parameter logic [5:0] OP_BEQ  = 6'h04,
    parameter logic [5:0] OP_LD   = 6'h05,
    parameter logic [5:0] OP_HLT  = 6'h3F
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic        Z,
    input  logic        C,
    input  logic        N,
    input  logic        O,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [2:0]  RF_FunSel,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  ARF_RegSel,
    output logic [1:0]  ARF_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxDSel,
    output logic        IR_Write,
    output logic        IR_LH,
    output logic        DR_E,
    output logic [1:0]  DR_FunSel,
    output logic        ALU_WF,
    output logic [4:0]  ALU_FunSel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  T,
    output logic        Halted,
    output logic        Illegal
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstate_t;

    tstate_t    t_q, t_d;
    logic       halted_q, halted_d;
    logic [5:0] opcode;
    logic [1:0] rx, ry;
    logic [3:0] rx_sel;

    assign opcode = IROut[15:10];
    assign rx     = IROut[9:8];
    assign ry     = IROut[7:6];
    // Active-low one-hot write select: R1 lives in bit 3.
    assign rx_sel = ~(4'b1000 >> rx);

    // Flags other than Z and the immediate are consumed by the datapath only.
    logic unused_inputs;
    assign unused_inputs = ^{C, N, O, IROut[5:0]};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            t_q      <= T0;
            halted_q <= 1'b0;
        end else begin
            t_q      <= t_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        t_d      = t_q;
        halted_d = halted_q;
        if (!halted_q) begin
            unique case (t_q)
                T0: t_d = T1;
                T1: t_d = T2;
                T2: begin
                    if (opcode == OP_LD) begin
                        t_d = T3;
                    end else if (opcode == OP_HLT) begin
                        t_d      = T2;
                        halted_d = 1'b1;
                    end else begin
                        t_d = T0;
                    end
                end
                T3: t_d = T0;
            endcase
        end
    end

    always_comb begin
        RF_RegSel   = 4'b1111;
        RF_ScrSel   = 4'b1111;
        RF_FunSel   = 3'b000;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        ARF_RegSel  = 3'b111;
        ARF_FunSel  = 2'b00;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxDSel     = 1'b0;
        IR_Write    = 1'b0;
        IR_LH       = 1'b0;
        DR_E        = 1'b0;
        DR_FunSel   = 2'b00;
        ALU_WF      = 1'b0;
        ALU_FunSel  = 5'b00000;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        Illegal     = 1'b0;
        // Reset and halt both force the quiescent set: no access, no write.
        if (!Reset && !halted_q) begin
            unique case (t_q)
                T0, T1: begin
                    ARF_OutDSel = 2'b00;
                    Mem_CS      = 1'b0;
                    IR_Write    = 1'b1;
                    IR_LH       = (t_q == T1);
                    ARF_RegSel  = 3'b011;
                    ARF_FunSel  = 2'b01;
                end
                T2: begin
                    case (opcode)
                        OP_NOP: ;
                        OP_INC: begin
                            RF_RegSel = rx_sel;
                            RF_FunSel = 3'b001;
                        end
                        OP_LDI: begin
                            MuxASel   = 2'b11;
                            RF_RegSel = rx_sel;
                            RF_FunSel = 3'b010;
                        end
                        OP_ADD: begin
                            RF_OutASel = {1'b0, rx};
                            RF_OutBSel = {1'b0, ry};
                            MuxDSel    = 1'b0;
                            ALU_FunSel = ALU_ADD;
                            ALU_WF     = 1'b1;
                            MuxASel    = 2'b00;
                            RF_RegSel  = rx_sel;
                            RF_FunSel  = 3'b010;
                        end
                        OP_BEQ: begin
                            if (Z) begin
                                MuxBSel    = 2'b11;
                                ARF_RegSel = 3'b011;
                                ARF_FunSel = 2'b10;
                            end
                        end
                        OP_LD: begin
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            DR_E        = 1'b1;
                            DR_FunSel   = 2'b10;
                        end
                        OP_HLT: ;
                        default: Illegal = 1'b1;
                    endcase
                end
                T3: begin
                    MuxASel   = 2'b10;
                    RF_RegSel = rx_sel;
                    RF_FunSel = 3'b010;
                end
            endcase
        end
    end

    assign T      = t_q;
    assign Halted = halted_q;

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Scoreboard bench for hardwired_control_unit: directed instruction vectors.
// Stimulus pushes hand-written expected output sets; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_hardwired_control_unit;

    typedef struct packed {
        logic [1:0] t;
        logic       halted;
        logic       illegal;
        logic [3:0] rf_regsel;
        logic [3:0] rf_scrsel;
        logic [2:0] rf_fun;
        logic [2:0] rf_outa;
        logic [2:0] rf_outb;
        logic [2:0] arf_regsel;
        logic [1:0] arf_fun;
        logic [1:0] arf_outc;
        logic [1:0] arf_outd;
        logic [1:0] muxa;
        logic [1:0] muxb;
        logic       muxd;
        logic       ir_write;
        logic       ir_lh;
        logic       dr_e;
        logic [1:0] dr_fun;
        logic       alu_wf;
        logic [4:0] alu_fun;
        logic       mem_wr;
        logic       mem_cs;
    } out_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IROut = 16'h0000;
    logic        Z = 1'b0, C = 1'b0, N = 1'b0, O = 1'b0;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [2:0]  RF_FunSel, RF_OutASel, RF_OutBSel, ARF_RegSel;
    logic [1:0]  ARF_FunSel, ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;
    logic        MuxDSel, IR_Write, IR_LH, DR_E, ALU_WF, Mem_WR, Mem_CS;
    logic [1:0]  DR_FunSel, T;
    logic [4:0]  ALU_FunSel;
    logic        Halted, Illegal;

    int errors = 0;
    int checks = 0;
    out_t  exp_q[$];
    string name_q[$];
    out_t  act;

    hardwired_control_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut),
        .Z(Z), .C(C), .N(N), .O(O),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
        .RF_FunSel(RF_FunSel), .RF_OutASel(RF_OutASel),
        .RF_OutBSel(RF_OutBSel), .ARF_RegSel(ARF_RegSel),
        .ARF_FunSel(ARF_FunSel), .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel), .MuxASel(MuxASel),
        .MuxBSel(MuxBSel), .MuxDSel(MuxDSel),
        .IR_Write(IR_Write), .IR_LH(IR_LH),
        .DR_E(DR_E), .DR_FunSel(DR_FunSel),
        .ALU_WF(ALU_WF), .ALU_FunSel(ALU_FunSel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .T(T), .Halted(Halted), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        act = '0;
        act.t          = T;
        act.halted     = Halted;
        act.illegal    = Illegal;
        act.rf_regsel  = RF_RegSel;
        act.rf_scrsel  = RF_ScrSel;
        act.rf_fun     = RF_FunSel;
        act.rf_outa    = RF_OutASel;
        act.rf_outb    = RF_OutBSel;
        act.arf_regsel = ARF_RegSel;
        act.arf_fun    = ARF_FunSel;
        act.arf_outc   = ARF_OutCSel;
        act.arf_outd   = ARF_OutDSel;
        act.muxa       = MuxASel;
        act.muxb       = MuxBSel;
        act.muxd       = MuxDSel;
        act.ir_write   = IR_Write;
        act.ir_lh      = IR_LH;
        act.dr_e       = DR_E;
        act.dr_fun     = DR_FunSel;
        act.alu_wf     = ALU_WF;
        act.alu_fun    = ALU_FunSel;
        act.mem_wr     = Mem_WR;
        act.mem_cs     = Mem_CS;
    end

    function automatic out_t idle(input logic [1:0] t, input logic h);
        out_t e;
        e = '0;
        e.t          = t;
        e.halted     = h;
        e.rf_regsel  = 4'b1111;
        e.rf_scrsel  = 4'b1111;
        e.arf_regsel = 3'b111;
        e.mem_cs     = 1'b1;
        return e;
    endfunction

    function automatic out_t fetch(input logic [1:0] t, input logic lh);
        out_t e;
        e = idle(t, 1'b0);
        e.mem_cs     = 1'b0;
        e.ir_write   = 1'b1;
        e.ir_lh      = lh;
        e.arf_regsel = 3'b011;
        e.arf_fun    = 2'b01;
        return e;
    endfunction

    // Monitor: the DUT presents a full output set every cycle.
    always @(negedge Clock) begin
        out_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    end

    task automatic step(input logic [15:0] ir, input logic z,
                        input logic rst, input out_t e, input string n);
        IROut = ir;
        Z     = z;
        Reset = rst;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetches(input logic [15:0] ir, input string n);
        step(ir, 1'b0, 1'b0, fetch(2'd0, 1'b0), {n, "_t0"});
        step(ir, 1'b0, 1'b0, fetch(2'd1, 1'b1), {n, "_t1"});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        out_t e;
        @(posedge Clock);
        #1;
        step(16'h0000, 1'b0, 1'b1, idle(2'd0, 1'b0), "reset_a");
        step(16'h0000, 1'b0, 1'b1, idle(2'd0, 1'b0), "reset_b");

        fetches(16'h0000, "nop");
        step(16'h0000, 1'b0, 1'b0, idle(2'd2, 1'b0), "nop_t2");

        fetches(16'h0A5C, "ldi");
        e = idle(2'd2, 1'b0);
        e.rf_regsel = 4'b1101;
        e.rf_fun    = 3'b010;
        e.muxa      = 2'b11;
        step(16'h0A5C, 1'b0, 1'b0, e, "ldi_t2");

        fetches(16'h0D40, "add");
        e = idle(2'd2, 1'b0);
        e.rf_outa   = 3'd1;
        e.rf_outb   = 3'd1;
        e.alu_fun   = 5'b10100;
        e.alu_wf    = 1'b1;
        e.rf_regsel = 4'b1011;
        e.rf_fun    = 3'b010;
        step(16'h0D40, 1'b0, 1'b0, e, "add_t2");

        fetches(16'h0440, "inc");
        e = idle(2'd2, 1'b0);
        e.rf_regsel = 4'b0111;
        e.rf_fun    = 3'b001;
        step(16'h0440, 1'b0, 1'b0, e, "inc_r1_t2");

        fetches(16'h1030, "beq_z1");
        e = idle(2'd2, 1'b0);
        e.muxb       = 2'b11;
        e.arf_regsel = 3'b011;
        e.arf_fun    = 2'b10;
        step(16'h1030, 1'b1, 1'b0, e, "beq_z1_t2");

        fetches(16'h1030, "beq_z0");
        step(16'h1030, 1'b0, 1'b0, idle(2'd2, 1'b0), "beq_z0_t2");

        fetches(16'h1700, "ld");
        e = idle(2'd2, 1'b0);
        e.arf_outd = 2'b10;
        e.mem_cs   = 1'b0;
        e.dr_e     = 1'b1;
        e.dr_fun   = 2'b10;
        step(16'h1700, 1'b0, 1'b0, e, "ld_t2");
        e = idle(2'd3, 1'b0);
        e.muxa      = 2'b10;
        e.rf_regsel = 4'b1110;
        e.rf_fun    = 3'b010;
        step(16'h1700, 1'b0, 1'b0, e, "ld_t3");

        fetches(16'h2000, "ill");
        e = idle(2'd2, 1'b0);
        e.illegal = 1'b1;
        step(16'h2000, 1'b0, 1'b0, e, "ill_t2");
        step(16'h2000, 1'b0, 1'b0, fetch(2'd0, 1'b0), "ill_after");

        step(16'h1700, 1'b0, 1'b0, fetch(2'd1, 1'b1), "ldrst_t1");
        e = idle(2'd2, 1'b0);
        e.arf_outd = 2'b10;
        e.mem_cs   = 1'b0;
        e.dr_e     = 1'b1;
        e.dr_fun   = 2'b10;
        step(16'h1700, 1'b0, 1'b0, e, "ldrst_t2");
        step(16'h1700, 1'b0, 1'b1, idle(2'd3, 1'b0), "ldrst_t3_reset");
        step(16'h0000, 1'b0, 1'b0, fetch(2'd0, 1'b0), "after_rst_t0");
        step(16'h0000, 1'b0, 1'b0, fetch(2'd1, 1'b1), "after_rst_t1");
        step(16'h0000, 1'b0, 1'b0, idle(2'd2, 1'b0), "after_rst_t2");

        fetches(16'hFC00, "hlt");
        step(16'hFC00, 1'b0, 1'b0, idle(2'd2, 1'b0), "hlt_t2");
        for (int i = 0; i < 10; i++)
            step(16'h0A5C, 1'b1, 1'b0, idle(2'd2, 1'b1), "halted");
        step(16'h0000, 1'b0, 1'b1, idle(2'd2, 1'b1), "hlt_reset");
        step(16'h0000, 1'b0, 1'b0, fetch(2'd0, 1'b0), "unhalt_t0");

        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
